// File: rtl/inst_encoder_pkg.sv
// ============================================================================
// Module      : inst_encoder_pkg
// Description : RV32I opcodes, encoder error codes and immediate range limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_encoder_pkg;

    localparam logic [6:0] c_op_arithmetic     = 7'b0110011;
    localparam logic [6:0] c_op_arithmetic_imm = 7'b0010011;
    localparam logic [6:0] c_op_load           = 7'b0000011;
    localparam logic [6:0] c_op_jalr           = 7'b1100111;
    localparam logic [6:0] c_op_store          = 7'b0100011;
    localparam logic [6:0] c_op_branch         = 7'b1100011;
    localparam logic [6:0] c_op_jal            = 7'b1101111;

    localparam logic [1:0] c_err_none      = 2'd0;
    localparam logic [1:0] c_err_bad_op    = 2'd1;
    localparam logic [1:0] c_err_range     = 2'd2;
    localparam logic [1:0] c_err_misalign  = 2'd3;

    localparam int c_imm12_min = -2048;
    localparam int c_imm12_max = 2047;
    localparam int c_shamt_min = 0;
    localparam int c_shamt_max = 31;
    localparam int c_imm13_min = -4096;
    localparam int c_imm13_max = 4094;
    localparam int c_imm21_min = -1048576;
    localparam int c_imm21_max = 1048574;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/inst_encoder_imm_packer.sv
// ============================================================================
// Module      : imm_packer
// Description : Packs decoded RV32I fields and a signed immediate into one
//               instruction word, flagging bad opcodes and bad immediates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_packer
    import inst_encoder_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic [1:0]  o_err_code
);

    logic signed [31:0] w_imm_s;
    logic               w_is_shift;

    assign w_imm_s    = i_imm;
    assign w_is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

    // Range is tested before alignment so a doubly bad value reports range.
    always_comb begin
        o_word     = '0;
        o_err_code = c_err_none;
        case (i_opcode)
            c_op_arithmetic: begin
                o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            c_op_arithmetic_imm, c_op_load, c_op_jalr: begin
                if ((i_opcode == c_op_arithmetic_imm) && w_is_shift) begin
                    if (w_imm_s < c_shamt_min || w_imm_s > c_shamt_max)
                        o_err_code = c_err_range;
                    else
                        o_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
                end else if (w_imm_s < c_imm12_min || w_imm_s > c_imm12_max) begin
                    o_err_code = c_err_range;
                end else begin
                    o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                end
            end
            c_op_store: begin
                if (w_imm_s < c_imm12_min || w_imm_s > c_imm12_max)
                    o_err_code = c_err_range;
                else
                    o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            end
            c_op_branch: begin
                if (w_imm_s < c_imm13_min || w_imm_s > c_imm13_max)
                    o_err_code = c_err_range;
                else if (i_imm[0])
                    o_err_code = c_err_misalign;
                else
                    o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                              i_imm[4:1], i_imm[11], i_opcode};
            end
            c_op_jal: begin
                if (w_imm_s < c_imm21_min || w_imm_s > c_imm21_max)
                    o_err_code = c_err_range;
                else if (i_imm[0])
                    o_err_code = c_err_misalign;
                else
                    o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            end
            default: o_err_code = c_err_bad_op;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
// ============================================================================
// Module      : inst_encoder
// Description : Encodes instruction requests and streams the words into
//               instruction memory through a one-deep output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [6:0]        req_opcode,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [31:0]       req_imm,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  words_written
);

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         din_q, din_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [31:0]         w_word;
    logic [1:0]          w_code;
    logic                w_accept;
    logic                w_complete;

    imm_packer u_imm_packer (
        .i_opcode   (req_opcode),
        .i_rd       (req_rd),
        .i_rs1      (req_rs1),
        .i_rs2      (req_rs2),
        .i_funct3   (req_funct3),
        .i_funct7   (req_funct7),
        .i_imm      (req_imm),
        .o_word     (w_word),
        .o_err_code (w_code)
    );

    assign req_ready  = (state_q == ST_ACTIVE) && (!out_valid_q || mem_ready);
    assign w_accept   = req_valid && req_ready;
    assign w_complete = out_valid_q && mem_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        addr_d      = addr_q;
        din_d       = din_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        cnt_d       = cnt_q;

        // A completing write frees the slot before a new word may take it.
        if (w_complete) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + ADDR_W'(4);
            if (cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_ACTIVE: begin
                if (w_accept && (w_code != c_err_none)) begin
                    err_d      = 1'b1;
                    err_code_d = w_code;
                    state_d    = ST_HALT;
                end else begin
                    if (w_accept) begin
                        out_valid_d = 1'b1;
                        din_d       = w_word;
                    end
                    if (finish)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_d)
                    state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (start) begin
            state_d     = ST_ACTIVE;
            out_valid_d = 1'b0;
            addr_d      = base_addr & ~ADDR_W'(3);
            din_d       = '0;
            err_d       = 1'b0;
            err_code_d  = c_err_none;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            err_q       <= 1'b0;
            err_code_q  <= c_err_none;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_write     = out_valid_q;
    assign mem_addr      = addr_q;
    assign mem_din       = din_q;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign words_written = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// Module      : tb_inst_encoder
// Description : Directed self-checking bench for inst_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder;

    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_i    = 7'b0010011;
    localparam logic [6:0] c_op_ld   = 7'b0000011;
    localparam logic [6:0] c_op_jalr = 7'b1100111;
    localparam logic [6:0] c_op_st   = 7'b0100011;
    localparam logic [6:0] c_op_br   = 7'b1100011;
    localparam logic [6:0] c_op_jal  = 7'b1101111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic        finish;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [31:0] req_imm;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_ready;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] words_written;

    int n_checks = 0;
    int n_fail   = 0;

    inst_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .finish        (finish),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_rd        (req_rd),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_funct3    (req_funct3),
        .req_funct7    (req_funct7),
        .req_imm       (req_imm),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .err           (err),
        .err_code      (err_code),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_opcode = op;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_funct3 = f3;
        req_funct7 = f7;
        req_imm    = imm;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic enc(input string tag, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp);
        send(tag, op, rd, rs1, rs2, f3, f7, imm);
        chk({tag, "_wr"}, 32'(mem_write), 32'd1);
        chk({tag, "_din"}, mem_din, exp);
    endtask

    task automatic restart(input string tag, input logic [31:0] base);
        base_addr = base;
        start     = 1'b1;
        step();
        start     = 1'b0;
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
        chk({tag, "_cnt"}, 32'(words_written), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic err_case(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] imm, input logic [1:0] code);
        send(tag, op, 5'd1, 5'd2, 5'd3, f3, 7'd0, imm);
        chk({tag, "_wr"}, 32'(mem_write), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_code"}, 32'(err_code), 32'(code));
        chk({tag, "_halt_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        step();
        chk({tag, "_nowr"}, 32'(mem_write), 32'd0);
        restart({tag, "_rst"}, 32'h100);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0; base_addr = '0;
        req_valid = 1'b0; req_opcode = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_funct3 = '0; req_funct7 = '0; req_imm = '0; mem_ready = 1'b1;
        step();
        step();
        chk("rst_wr",    32'(mem_write), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_din",   mem_din, 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_code",  32'(err_code), 32'd0);
        chk("rst_cnt",   32'(words_written), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        reset = 1'b0;
        step();

        finish = 1'b1;
        step();
        finish = 1'b0;
        chk("idle_finish_busy", 32'(busy), 32'd0);

        // addi x1,x0,5 at 0x100
        restart("start1", 32'h100);
        chk("start1_busy", 32'(busy), 32'd1);
        chk("start1_addr", mem_addr, 32'h100);
        enc("addi", c_op_i, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h0050_0093);
        chk("addi_addr", mem_addr, 32'h100);
        step();
        chk("addi_cnt", 32'(words_written), 32'd1);
        chk("addi_idle_wr", 32'(mem_write), 32'd0);
        chk("addi_next_addr", mem_addr, 32'h104);

        // sw then beq back to back; base low bits are dropped
        restart("start2", 32'h103);
        chk("start2_addr", mem_addr, 32'h100);
        enc("sw", c_op_st, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423);
        chk("sw_addr", mem_addr, 32'h100);
        enc("beq", c_op_br, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd4, 32'hFE00_0EE3);
        chk("beq_addr", mem_addr, 32'h104);
        chk("beq_cnt", 32'(words_written), 32'd1);
        step();
        chk("b2b_cnt", 32'(words_written), 32'd2);
        chk("b2b_addr", mem_addr, 32'h108);

        // jal x0,0 under a 3-cycle stall
        mem_ready = 1'b0;
        enc("jal0", c_op_jal, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 32'h0000_006F);
        chk("jal0_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_wr", 32'(mem_write), 32'd1);
            chk("stall_din", mem_din, 32'h0000_006F);
            chk("stall_addr", mem_addr, 32'h108);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        mem_ready = 1'b1;
        step();
        chk("stall_done_cnt", 32'(words_written), 32'd3);
        chk("stall_done_wr", 32'(mem_write), 32'd0);
        chk("stall_done_addr", mem_addr, 32'h10C);
        step();
        chk("stall_once_cnt", 32'(words_written), 32'd3);

        enc("add",  c_op_r,    5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3);
        enc("sub",  c_op_r,    5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0,         32'h4020_81B3);
        enc("slli", c_op_i,    5'd5, 5'd6, 5'd0, 3'b001, 7'h00, 32'd3,         32'h0033_1293);
        enc("srai", c_op_i,    5'd5, 5'd6, 5'd0, 3'b101, 7'h20, 32'd31,        32'h41F3_5293);
        enc("lw",   c_op_ld,   5'd5, 5'd6, 5'd0, 3'b010, 7'h00, -32'sd1,       32'hFFF3_2283);
        enc("jalr", c_op_jalr, 5'd1, 5'd5, 5'd0, 3'b000, 7'h00, 32'd2047,      32'h7FF2_80E7);
        enc("bmin", c_op_br,   5'd0, 5'd0, 5'd0, 3'b000, 7'h00, -32'sd4096,    32'h8000_0063);
        enc("jmax", c_op_jal,  5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1048574,   32'h7FFF_F06F);
        step();
        chk("table_cnt", 32'(words_written), 32'd11);

        err_case("e_addi_hi", c_op_i,    3'b000, 32'd2048,    2'd2);
        err_case("e_jal_odd", c_op_jal,  3'b000, 32'd3,       2'd3);
        err_case("e_badop",   7'h7F,     3'b000, 32'd0,       2'd1);
        err_case("e_br_both", c_op_br,   3'b000, 32'd4095,    2'd2);
        err_case("e_shamt",   c_op_i,    3'b001, 32'd32,      2'd2);
        err_case("e_st_lo",   c_op_st,   3'b010, -32'sd2049,  2'd2);

        // finish with one word pending
        mem_ready = 1'b0;
        enc("fin_addi", c_op_i, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h0050_0093);
        finish = 1'b1;
        step();
        finish = 1'b0;
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_ready", 32'(req_ready), 32'd0);
        chk("drain_wr", 32'(mem_write), 32'd1);
        mem_ready = 1'b1;
        step();
        chk("drain_done_wr", 32'(mem_write), 32'd0);
        chk("drain_done_busy", 32'(busy), 32'd0);
        chk("drain_done_ready", 32'(req_ready), 32'd0);
        chk("drain_done_cnt", 32'(words_written), 32'd1);

        // reset during a stalled write
        restart("start3", 32'h200);
        mem_ready = 1'b0;
        enc("rst_addi", c_op_i, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h0050_0093);
        #2;
        reset = 1'b1;
        #1;
        chk("async_wr",    32'(mem_write), 32'd0);
        chk("async_addr",  mem_addr, 32'd0);
        chk("async_din",   mem_din, 32'd0);
        chk("async_busy",  32'(busy), 32'd0);
        chk("async_ready", 32'(req_ready), 32'd0);
        chk("async_cnt",   32'(words_written), 32'd0);
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
